// File: rtl/fu_issue_scheduler.sv
// Functional-unit occupancy tracker: credit counters for pipelined FUs, busy timers for
// non-pipelined FUs, producing the per-FU ready mask plus sticky protocol-error flags.
module fu_issue_scheduler #(
  parameter int                      NUM_FU       = 4,
  parameter int                      LAT_W        = 4,
  parameter int                      MAX_CREDITS  = 4,
  parameter logic [NUM_FU-1:0]       FU_PIPE_MASK = 4'b0011,
  parameter logic [NUM_FU*LAT_W-1:0] FU_LAT       = {4'd8, 4'd3, 4'd1, 4'd1}
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_FU-1:0] issue_v_i,
  input  logic [NUM_FU-1:0] fu_done_i,
  input  logic              flush_i,
  output logic [NUM_FU-1:0] fu_ready_o,
  output logic              idle_o,
  output logic [NUM_FU-1:0] err_o,
  output logic              multi_issue_err_o
);

  localparam int              CNT_W    = $clog2(MAX_CREDITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CREDITS);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LAT_W-1:0] TMR_ZERO = LAT_W'(0);
  localparam logic [LAT_W-1:0] TMR_ONE  = LAT_W'(1);

  // True when more than one bit of the vector is set.
  function automatic logic multi_hot(input logic [NUM_FU-1:0] v);
    return |(v & (v - NUM_FU'(1)));
  endfunction

  logic [CNT_W-1:0]  cnt_r     [NUM_FU];
  logic [CNT_W-1:0]  cnt_nxt_s [NUM_FU];
  logic [LAT_W-1:0]  tmr_r     [NUM_FU];
  logic [LAT_W-1:0]  tmr_nxt_s [NUM_FU];
  logic [NUM_FU-1:0] err_r;
  logic [NUM_FU-1:0] err_nxt_s;
  logic              multi_err_r;
  logic              multi_err_nxt_s;
  logic [NUM_FU-1:0] ready_s;
  logic              idle_s;

  // Per-FU next-state: credit bookkeeping or busy countdown depending on FU mode.
  always_comb begin
    for (int j = 0; j < NUM_FU; j++) begin
      cnt_nxt_s[j] = cnt_r[j];
      tmr_nxt_s[j] = tmr_r[j];
      err_nxt_s[j] = err_r[j];
      if (FU_PIPE_MASK[j]) begin
        tmr_nxt_s[j] = TMR_ZERO;
        if (flush_i) begin
          cnt_nxt_s[j] = CNT_ZERO;
        end else begin
          case ({issue_v_i[j], fu_done_i[j]})
            2'b10: begin
              if (cnt_r[j] == CNT_MAX) begin
                err_nxt_s[j] = 1'b1;
              end else begin
                cnt_nxt_s[j] = cnt_r[j] + CNT_ONE;
              end
            end
            2'b01: begin
              if (cnt_r[j] == CNT_ZERO) begin
                err_nxt_s[j] = 1'b1;
              end else begin
                cnt_nxt_s[j] = cnt_r[j] - CNT_ONE;
              end
            end
            2'b11: begin
              // Issue into a full FU is still a protocol violation even if a credit returns.
              if (cnt_r[j] == CNT_MAX) begin
                err_nxt_s[j] = 1'b1;
              end else begin
                cnt_nxt_s[j] = cnt_r[j];
              end
            end
            default: begin
              cnt_nxt_s[j] = cnt_r[j];
            end
          endcase
        end
      end else begin
        cnt_nxt_s[j] = CNT_ZERO;
        if (issue_v_i[j] && !flush_i && (tmr_r[j] == TMR_ZERO)) begin
          tmr_nxt_s[j] = FU_LAT[j*LAT_W +: LAT_W];
        end else if (issue_v_i[j] && !flush_i) begin
          err_nxt_s[j] = 1'b1;
          tmr_nxt_s[j] = tmr_r[j] - TMR_ONE;
        end else if (tmr_r[j] != TMR_ZERO) begin
          tmr_nxt_s[j] = tmr_r[j] - TMR_ONE;
        end else begin
          tmr_nxt_s[j] = tmr_r[j];
        end
      end
    end
  end

  // Sticky flag for illegal multi-hot issue vectors.
  always_comb begin
    multi_err_nxt_s = multi_err_r;
    if (multi_hot(issue_v_i)) begin
      multi_err_nxt_s = 1'b1;
    end else begin
      multi_err_nxt_s = multi_err_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int j = 0; j < NUM_FU; j++) begin
        cnt_r[j] <= CNT_ZERO;
        tmr_r[j] <= TMR_ZERO;
      end
      err_r       <= '0;
      multi_err_r <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_FU; j++) begin
        cnt_r[j] <= cnt_nxt_s[j];
        tmr_r[j] <= tmr_nxt_s[j];
      end
      err_r       <= err_nxt_s;
      multi_err_r <= multi_err_nxt_s;
    end
  end

  // Ready mask and idle detection from registered state only.
  always_comb begin
    ready_s = '0;
    idle_s  = 1'b1;
    for (int j = 0; j < NUM_FU; j++) begin
      if (FU_PIPE_MASK[j]) begin
        ready_s[j] = (cnt_r[j] < CNT_MAX);
      end else begin
        ready_s[j] = (tmr_r[j] == TMR_ZERO);
      end
      if ((cnt_r[j] != CNT_ZERO) || (tmr_r[j] != TMR_ZERO)) begin
        idle_s = 1'b0;
      end else begin
        idle_s = idle_s;
      end
    end
  end

  // Reset forces a quiet, blocked interface regardless of stored state.
  always_comb begin
    if (reset_i) begin
      fu_ready_o        = '0;
      idle_o            = 1'b1;
      err_o             = '0;
      multi_issue_err_o = 1'b0;
    end else begin
      fu_ready_o        = ready_s;
      idle_o            = idle_s;
      err_o             = err_r;
      multi_issue_err_o = multi_err_r;
    end
  end

endmodule
